// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register writeback countdown scoreboard that stalls ID on RAW hazards; define FORWARDING_EN for EXE/MEM forwarding selects (load-use still stalls)
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int WB_LAT     = 2,
    parameter int CNT_W      = $clog2(WB_LAT + 1),
    parameter int STAT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    src1,
    input  logic [REG_ADDR_W-1:0]    src2,
    input  logic                     two_src,
    input  logic                     id_wb_en,
    input  logic [REG_ADDR_W-1:0]    id_dest,
    input  logic                     id_is_load,
    input  logic                     flush,
    output logic                     hazard,
    output logic [1:0]               fwd_sel1,
    output logic [1:0]               fwd_sel2,
    output logic [2**REG_ADDR_W-1:0] busy_mask,
    output logic [STAT_W-1:0]        stall_count
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam logic [CNT_W-1:0] LAT_EXE = CNT_W'(WB_LAT);
    localparam logic [CNT_W-1:0] LAT_MEM = CNT_W'(WB_LAT - 1);

    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [CNT_W-1:0]  c1, c2;
    logic              pend1, pend2, stall1, stall2, issue;

    // source lookup: a source is pending while its producer has not reached the regfile
    always_comb begin
        c1    = cnt_q[src1];
        c2    = cnt_q[src2];
        pend1 = c1 != '0;
        pend2 = two_src && c2 != '0;
    end

`ifdef FORWARDING_EN
    logic [NUM_REGS-1:0] ld_q, ld_d;

    // bypass from EXE (cnt==WB_LAT) or MEM (cnt==WB_LAT-1); a load still in EXE has no data yet
    always_comb begin
        fwd_sel1 = !pend1 ? 2'd0 : c1 == LAT_EXE ? 2'd1 : c1 == LAT_MEM ? 2'd2 : 2'd0;
        fwd_sel2 = !pend2 ? 2'd0 : c2 == LAT_EXE ? 2'd1 : c2 == LAT_MEM ? 2'd2 : 2'd0;
        stall1   = pend1 && (fwd_sel1 == 2'd0 || (c1 == LAT_EXE && ld_q[src1]));
        stall2   = pend2 && (fwd_sel2 == 2'd0 || (c2 == LAT_EXE && ld_q[src2]));
    end

    // remember whether the latest producer of each register is a load
    always_comb begin
        ld_d = ld_q;
        if (issue) ld_d[id_dest] = id_is_load;
    end

    // load-flag register
    always_ff @(posedge clk) begin
        ld_q <= rst ? '0 : ld_d;
    end
`else
    logic unused_is_load;

    assign unused_is_load = id_is_load;
    assign fwd_sel1       = 2'd0;
    assign fwd_sel2       = 2'd0;
    assign stall1         = pend1;
    assign stall2         = pend2;
`endif

    assign hazard      = id_valid && !flush && (stall1 || stall2);
    assign issue       = id_valid && !flush && !hazard && id_wb_en;
    assign stall_count = stat_q;

    // countdown every pending entry; a new issue reloads its destination (WAW just restarts it)
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r]     = cnt_q[r] != '0 ? cnt_q[r] - CNT_W'(1) : '0;
            busy_mask[r] = cnt_q[r] != '0;
        end
        if (issue) cnt_d[id_dest] = LAT_EXE;
        stat_d = hazard && stat_q != '1 ? stat_q + STAT_W'(1) : stat_q;
    end

    // scoreboard and saturating stall statistic
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '{default: '0};
            stat_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            stat_q <= stat_d;
        end
    end
endmodule
